// File: rtl/ysyx_25010008_axi_rr_arbiter_if.sv
// Upstream per-master AXI4 bundle and downstream io_master AXI4 bundle
// shared by the N:1 arbiter and its neighbours.
interface ysyx_25010008_axi_rr_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
);
    localparam int N  = NUM_MASTERS;
    localparam int SW = DATA_W / 8;

    logic [N-1:0]        m_arvalid;
    logic [N-1:0]        m_arready;
    logic [N*ADDR_W-1:0] m_araddr;
    logic [N*8-1:0]      m_arlen;
    logic [N*3-1:0]      m_arsize;
    logic [N-1:0]        m_rvalid;
    logic [N-1:0]        m_rready;
    logic [DATA_W-1:0]   m_rdata;
    logic [1:0]          m_rresp;
    logic                m_rlast;
    logic [N-1:0]        m_awvalid;
    logic [N-1:0]        m_awready;
    logic [N*ADDR_W-1:0] m_awaddr;
    logic [N*8-1:0]      m_awlen;
    logic [N*3-1:0]      m_awsize;
    logic [N-1:0]        m_wvalid;
    logic [N-1:0]        m_wready;
    logic [N*DATA_W-1:0] m_wdata;
    logic [N*SW-1:0]     m_wstrb;
    logic [N-1:0]        m_wlast;
    logic [N-1:0]        m_bvalid;
    logic [N-1:0]        m_bready;
    logic [1:0]          m_bresp;

    modport master (
        output m_arvalid, m_araddr, m_arlen, m_arsize, m_rready,
        output m_awvalid, m_awaddr, m_awlen, m_awsize,
        output m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
        input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
        input  m_awready, m_wready, m_bvalid, m_bresp
    );

    modport slave (
        input  m_arvalid, m_araddr, m_arlen, m_arsize, m_rready,
        input  m_awvalid, m_awaddr, m_awlen, m_awsize,
        input  m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
        output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
        output m_awready, m_wready, m_bvalid, m_bresp
    );
endinterface

interface ysyx_25010008_axi_io_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SW = DATA_W / 8;

    logic              io_master_awready;
    logic              io_master_awvalid;
    logic [ADDR_W-1:0] io_master_awaddr;
    logic [3:0]        io_master_awid;
    logic [7:0]        io_master_awlen;
    logic [2:0]        io_master_awsize;
    logic [1:0]        io_master_awburst;
    logic              io_master_wready;
    logic              io_master_wvalid;
    logic [DATA_W-1:0] io_master_wdata;
    logic [SW-1:0]     io_master_wstrb;
    logic              io_master_wlast;
    logic              io_master_bready;
    logic              io_master_bvalid;
    logic [1:0]        io_master_bresp;
    logic [3:0]        io_master_bid;
    logic              io_master_arready;
    logic              io_master_arvalid;
    logic [ADDR_W-1:0] io_master_araddr;
    logic [3:0]        io_master_arid;
    logic [7:0]        io_master_arlen;
    logic [2:0]        io_master_arsize;
    logic [1:0]        io_master_arburst;
    logic              io_master_rready;
    logic              io_master_rvalid;
    logic [1:0]        io_master_rresp;
    logic [DATA_W-1:0] io_master_rdata;
    logic              io_master_rlast;
    logic [3:0]        io_master_rid;

    modport master (
        output io_master_awvalid, io_master_awaddr, io_master_awid,
        output io_master_awlen, io_master_awsize, io_master_awburst,
        output io_master_wvalid, io_master_wdata, io_master_wstrb,
        output io_master_wlast, io_master_bready,
        output io_master_arvalid, io_master_araddr, io_master_arid,
        output io_master_arlen, io_master_arsize, io_master_arburst,
        output io_master_rready,
        input  io_master_awready, io_master_wready,
        input  io_master_bvalid, io_master_bresp, io_master_bid,
        input  io_master_arready, io_master_rvalid, io_master_rresp,
        input  io_master_rdata, io_master_rlast, io_master_rid
    );

    modport slave (
        input  io_master_awvalid, io_master_awaddr, io_master_awid,
        input  io_master_awlen, io_master_awsize, io_master_awburst,
        input  io_master_wvalid, io_master_wdata, io_master_wstrb,
        input  io_master_wlast, io_master_bready,
        input  io_master_arvalid, io_master_araddr, io_master_arid,
        input  io_master_arlen, io_master_arsize, io_master_arburst,
        input  io_master_rready,
        output io_master_awready, io_master_wready,
        output io_master_bvalid, io_master_bresp, io_master_bid,
        output io_master_arready, io_master_rvalid, io_master_rresp,
        output io_master_rdata, io_master_rlast, io_master_rid
    );
endinterface

// File: rtl/ysyx_25010008_axi_rr_arbiter.sv
// N:1 AXI4 arbiter, one downstream transaction in flight at a time,
// round-robin or fixed-priority grant.
module ysyx_25010008_axi_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ARB_MODE    = 0
) (
    input  logic clock,
    input  logic reset,
    ysyx_25010008_axi_rr_arbiter_if.slave up,
    ysyx_25010008_axi_io_if.master        bus,
    output logic resp_err
);
    localparam int N  = NUM_MASTERS;
    localparam int SW = DATA_W / 8;
    localparam int GW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;

    state_t        state;
    logic [GW-1:0] g;
    logic [GW-1:0] ptr;
    logic [GW-1:0] win;
    logic [GW-1:0] base;
    logic [GW-1:0] nxt;
    logic          found;
    logic [N-1:0]  req;
    logic          ar_hs;
    logic          r_hs;
    logic          r_done;
    logic          aw_hs;
    logic          w_done;
    logic          b_hs;

    assign req  = up.m_arvalid | up.m_awvalid;
    assign base = (ARB_MODE == 1) ? '0 : ptr;
    assign nxt  = (int'(g) == N - 1) ? '0 : g + 1'b1;

    // Valids/readies are zero outside their state, so these are state-qualified
    assign ar_hs  = bus.io_master_arvalid & bus.io_master_arready;
    assign r_hs   = bus.io_master_rvalid & bus.io_master_rready;
    assign r_done = r_hs & bus.io_master_rlast;
    assign aw_hs  = bus.io_master_awvalid & bus.io_master_awready;
    assign w_done = bus.io_master_wvalid & bus.io_master_wready
                  & bus.io_master_wlast;
    assign b_hs   = bus.io_master_bvalid & bus.io_master_bready;

    always_comb begin
        int k;
        k     = 0;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = int'(base) + i;
            if (k >= N) k = k - N;
            if (!found && req[k]) begin
                found = 1'b1;
                win   = GW'(k);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            g        <= '0;
            ptr      <= '0;
            resp_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (found) begin
                    g     <= win;
                    state <= up.m_arvalid[win] ? AR : AW;
                end
                AR: if (ar_hs) state <= R;
                R: if (r_done) begin
                    state <= IDLE;
                    ptr   <= nxt;
                end
                AW: if (aw_hs) state <= W;
                W: if (w_done) state <= B;
                B: if (b_hs) begin
                    state <= IDLE;
                    ptr   <= nxt;
                end
                default: state <= IDLE;
            endcase
            if ((r_hs && bus.io_master_rresp != 2'b00) ||
                (b_hs && bus.io_master_bresp != 2'b00))
                resp_err <= 1'b1;
        end
    end

    always_comb begin
        up.m_arready          = '0;
        up.m_rvalid           = '0;
        up.m_rdata            = '0;
        up.m_rresp            = '0;
        up.m_rlast            = 1'b0;
        up.m_awready          = '0;
        up.m_wready           = '0;
        up.m_bvalid           = '0;
        up.m_bresp            = '0;
        bus.io_master_arvalid = 1'b0;
        bus.io_master_araddr  = '0;
        bus.io_master_arid    = '0;
        bus.io_master_arlen   = '0;
        bus.io_master_arsize  = '0;
        bus.io_master_arburst = '0;
        bus.io_master_rready  = 1'b0;
        bus.io_master_awvalid = 1'b0;
        bus.io_master_awaddr  = '0;
        bus.io_master_awid    = '0;
        bus.io_master_awlen   = '0;
        bus.io_master_awsize  = '0;
        bus.io_master_awburst = '0;
        bus.io_master_wvalid  = 1'b0;
        bus.io_master_wdata   = '0;
        bus.io_master_wstrb   = '0;
        bus.io_master_wlast   = 1'b0;
        bus.io_master_bready  = 1'b0;
        unique case (state)
            AR: begin
                bus.io_master_arvalid = up.m_arvalid[g];
                bus.io_master_araddr  = up.m_araddr[int'(g)*ADDR_W +: ADDR_W];
                bus.io_master_arlen   = up.m_arlen[int'(g)*8 +: 8];
                bus.io_master_arsize  = up.m_arsize[int'(g)*3 +: 3];
                bus.io_master_arid    = 4'(g);
                bus.io_master_arburst = 2'b01;
                up.m_arready[g]       = bus.io_master_arready;
            end
            R: begin
                up.m_rvalid[g]       = bus.io_master_rvalid;
                bus.io_master_rready = up.m_rready[g];
                up.m_rdata           = bus.io_master_rdata;
                up.m_rresp           = bus.io_master_rresp;
                up.m_rlast           = bus.io_master_rlast;
            end
            AW: begin
                bus.io_master_awvalid = up.m_awvalid[g];
                bus.io_master_awaddr  = up.m_awaddr[int'(g)*ADDR_W +: ADDR_W];
                bus.io_master_awlen   = up.m_awlen[int'(g)*8 +: 8];
                bus.io_master_awsize  = up.m_awsize[int'(g)*3 +: 3];
                bus.io_master_awid    = 4'(g);
                bus.io_master_awburst = 2'b01;
                up.m_awready[g]       = bus.io_master_awready;
            end
            W: begin
                bus.io_master_wvalid = up.m_wvalid[g];
                bus.io_master_wdata  = up.m_wdata[int'(g)*DATA_W +: DATA_W];
                bus.io_master_wstrb  = up.m_wstrb[int'(g)*SW +: SW];
                bus.io_master_wlast  = up.m_wlast[g];
                up.m_wready[g]       = bus.io_master_wready;
            end
            B: begin
                up.m_bvalid[g]       = bus.io_master_bvalid;
                bus.io_master_bready = up.m_bready[g];
                up.m_bresp           = bus.io_master_bresp;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ysyx_25010008_axi_rr_arbiter.sv
// Directed bench: RR N=2 and N=4, fixed priority, write burst,
// sticky error flag and mid-burst reset.
module tb_ysyx_25010008_axi_rr_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic err2, err4, errf;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    ysyx_25010008_axi_rr_arbiter_if #(.NUM_MASTERS(2)) u2();
    ysyx_25010008_axi_io_if d2();
    ysyx_25010008_axi_rr_arbiter_if #(.NUM_MASTERS(4)) u4();
    ysyx_25010008_axi_io_if d4();
    ysyx_25010008_axi_rr_arbiter_if #(.NUM_MASTERS(4)) uf();
    ysyx_25010008_axi_io_if df();

    ysyx_25010008_axi_rr_arbiter #(.NUM_MASTERS(2), .ARB_MODE(0)) dut2 (
        .clock(clock), .reset(reset), .up(u2), .bus(d2), .resp_err(err2));
    ysyx_25010008_axi_rr_arbiter #(.NUM_MASTERS(4), .ARB_MODE(0)) dut4 (
        .clock(clock), .reset(reset), .up(u4), .bus(d4), .resp_err(err4));
    ysyx_25010008_axi_rr_arbiter #(.NUM_MASTERS(4), .ARB_MODE(1)) dutf (
        .clock(clock), .reset(reset), .up(uf), .bus(df), .resp_err(errf));

    typedef struct {
        logic [3:0] arv;
        logic [3:0] awv;
        logic       rd;
        logic [3:0] id;
    } vec_t;
    vec_t tbl[10];

    logic [3:0] ids2[$];
    logic [3:0] idsf[$];

    always @(negedge clock) begin
        if (!reset && d2.io_master_arvalid && d2.io_master_arready)
            ids2.push_back(d2.io_master_arid);
        if (!reset && df.io_master_arvalid && df.io_master_arready)
            idsf.push_back(df.io_master_arid);
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] raddr(input logic [3:0] i);
        return 32'h1000_0000 + 32'(i) * 32'h100;
    endfunction

    function automatic logic [31:0] waddr(input logic [3:0] i);
        return 32'h2000_0000 + 32'(i) * 32'h100;
    endfunction

    task automatic run_vec(input vec_t v);
        int n;
        n = 0;
        @(negedge clock);
        u4.m_arvalid = v.arv;
        u4.m_awvalid = v.awv;
        do begin
            @(negedge clock);
            n++;
        end while (!(d4.io_master_arvalid || d4.io_master_awvalid) && n < 6);
        chk("grant_latency", 64'(n), 64'd1);
        chk("is_read", {63'd0, d4.io_master_arvalid}, {63'd0, v.rd});
        if (v.rd) begin
            chk("arid", {60'd0, d4.io_master_arid}, {60'd0, v.id});
            chk("araddr", {32'd0, d4.io_master_araddr}, {32'd0, raddr(v.id)});
            d4.io_master_arready = 1'b1;
            @(negedge clock);
            d4.io_master_arready = 1'b0;
            u4.m_arvalid = '0;
            u4.m_awvalid = '0;
            d4.io_master_rvalid = 1'b1;
            d4.io_master_rlast = 1'b1;
            #1;
            chk("r_route", {60'd0, u4.m_rvalid}, {60'd0, 4'b1 << v.id});
            @(negedge clock);
            d4.io_master_rvalid = 1'b0;
            d4.io_master_rlast = 1'b0;
        end else begin
            chk("awid", {60'd0, d4.io_master_awid}, {60'd0, v.id});
            chk("awaddr", {32'd0, d4.io_master_awaddr}, {32'd0, waddr(v.id)});
            d4.io_master_awready = 1'b1;
            @(negedge clock);
            d4.io_master_awready = 1'b0;
            u4.m_arvalid = '0;
            u4.m_awvalid = '0;
            u4.m_wvalid[v.id] = 1'b1;
            u4.m_wlast[v.id] = 1'b1;
            d4.io_master_wready = 1'b1;
            @(negedge clock);
            u4.m_wvalid = '0;
            u4.m_wlast = '0;
            d4.io_master_wready = 1'b0;
            d4.io_master_bvalid = 1'b1;
            #1;
            chk("b_route", {60'd0, u4.m_bvalid}, {60'd0, 4'b1 << v.id});
            @(negedge clock);
            d4.io_master_bvalid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        u2.m_arvalid = '0; u2.m_araddr = '0; u2.m_arlen = '0;
        u2.m_arsize = '0; u2.m_rready = 2'b11; u2.m_awvalid = '0;
        u2.m_awaddr = '0; u2.m_awlen = '0; u2.m_awsize = '0;
        u2.m_wvalid = '0; u2.m_wdata = '0; u2.m_wstrb = '0;
        u2.m_wlast = '0; u2.m_bready = '0;
        uf.m_arvalid = '0; uf.m_araddr = '0; uf.m_arlen = '0;
        uf.m_arsize = '0; uf.m_rready = '1; uf.m_awvalid = '0;
        uf.m_awaddr = '0; uf.m_awlen = '0; uf.m_awsize = '0;
        uf.m_wvalid = '0; uf.m_wdata = '0; uf.m_wstrb = '0;
        uf.m_wlast = '0; uf.m_bready = '0;
        u4.m_arvalid = '0; u4.m_arlen = '0; u4.m_arsize = '0;
        u4.m_rready = '1; u4.m_awvalid = '0; u4.m_awlen = '0;
        u4.m_awsize = '0; u4.m_wvalid = '0; u4.m_wdata = '0;
        u4.m_wstrb = '1; u4.m_wlast = '0; u4.m_bready = '1;
        for (int i = 0; i < 4; i++) begin
            u4.m_araddr[i*32 +: 32] = raddr(4'(i));
            u4.m_awaddr[i*32 +: 32] = waddr(4'(i));
        end
        d2.io_master_awready = 0; d2.io_master_wready = 0;
        d2.io_master_bvalid = 0; d2.io_master_bresp = 0; d2.io_master_bid = 0;
        d2.io_master_arready = 1; d2.io_master_rvalid = 1;
        d2.io_master_rresp = 0; d2.io_master_rdata = 0;
        d2.io_master_rlast = 1; d2.io_master_rid = 0;
        df.io_master_awready = 0; df.io_master_wready = 0;
        df.io_master_bvalid = 0; df.io_master_bresp = 0; df.io_master_bid = 0;
        df.io_master_arready = 1; df.io_master_rvalid = 1;
        df.io_master_rresp = 0; df.io_master_rdata = 0;
        df.io_master_rlast = 1; df.io_master_rid = 0;
        d4.io_master_awready = 0; d4.io_master_wready = 0;
        d4.io_master_bvalid = 0; d4.io_master_bresp = 0; d4.io_master_bid = 0;
        d4.io_master_arready = 0; d4.io_master_rvalid = 0;
        d4.io_master_rresp = 0; d4.io_master_rdata = 32'hCAFE_0000;
        d4.io_master_rlast = 0; d4.io_master_rid = 4'hF;

        tbl[0] = '{4'b1111, 4'b0000, 1'b1, 4'd0};
        tbl[1] = '{4'b1111, 4'b0000, 1'b1, 4'd1};
        tbl[2] = '{4'b1111, 4'b0000, 1'b1, 4'd2};
        tbl[3] = '{4'b1111, 4'b0000, 1'b1, 4'd3};
        tbl[4] = '{4'b1111, 4'b0000, 1'b1, 4'd0};
        tbl[5] = '{4'b0000, 4'b0001, 1'b0, 4'd0};
        tbl[6] = '{4'b0100, 4'b0100, 1'b1, 4'd2};
        tbl[7] = '{4'b0010, 4'b1000, 1'b0, 4'd3};
        tbl[8] = '{4'b1000, 4'b0010, 1'b0, 4'd1};
        tbl[9] = '{4'b0011, 4'b0000, 1'b1, 4'd0};

        // Reset state, with live address payloads on the inputs
        @(negedge clock);
        u4.m_arvalid = 4'b0001;
        #1;
        chk("rst_arvalid", {63'd0, d4.io_master_arvalid}, 64'd0);
        chk("rst_araddr", {32'd0, d4.io_master_araddr}, 64'd0);
        chk("rst_arready", {60'd0, u4.m_arready}, 64'd0);
        chk("rst_rready", {63'd0, d4.io_master_rready}, 64'd0);
        chk("rst_err", {63'd0, err4}, 64'd0);
        chk("rst_arid", {60'd0, d4.io_master_arid}, 64'd0);
        @(negedge clock);
        u4.m_arvalid = '0;
        reset = 1'b0;

        // N=2 and fixed priority, continuous requests
        u2.m_arvalid = 2'b11;
        uf.m_arvalid = 4'b0101;
        repeat (14) @(negedge clock);
        u2.m_arvalid = '0;
        uf.m_arvalid = '0;
        chk("n2_count", {63'd0, ids2.size() >= 4}, 64'd1);
        if (ids2.size() >= 4)
            for (int i = 0; i < 4; i++)
                chk("n2_order", {60'd0, ids2[i]}, 64'(i % 2));
        chk("fix_count", {63'd0, idsf.size() >= 4}, 64'd1);
        foreach (idsf[i]) chk("fix_grant", {60'd0, idsf[i]}, 64'd0);

        for (int i = 0; i < 10; i++) run_vec(tbl[i]);

        // Four-beat write burst from m1 (ptr is 1 here)
        @(negedge clock);
        u4.m_awvalid = 4'b0010;
        u4.m_awlen[15:8] = 8'd3;
        @(negedge clock);
        chk("wb_awvalid", {63'd0, d4.io_master_awvalid}, 64'd1);
        chk("wb_awid", {60'd0, d4.io_master_awid}, 64'd1);
        chk("wb_awlen", {56'd0, d4.io_master_awlen}, 64'd3);
        chk("wb_awburst", {62'd0, d4.io_master_awburst}, 64'd1);
        d4.io_master_awready = 1'b1;
        @(negedge clock);
        d4.io_master_awready = 1'b0;
        u4.m_awvalid = '0;
        d4.io_master_wready = 1'b1;
        u4.m_wvalid = 4'b0010;
        for (int b = 0; b < 4; b++) begin
            u4.m_wdata[63:32] = 32'hD000 + 32'(b);
            u4.m_wlast[1] = (b == 3);
            #1;
            chk("wb_wvalid", {63'd0, d4.io_master_wvalid}, 64'd1);
            chk("wb_wdata", {32'd0, d4.io_master_wdata}, 64'hD000 + 64'(b));
            chk("wb_wlast", {63'd0, d4.io_master_wlast}, 64'(b == 3));
            chk("wb_wready", {60'd0, u4.m_wready}, 64'b0010);
            @(negedge clock);
        end
        u4.m_wvalid = '0;
        u4.m_wlast = '0;
        d4.io_master_wready = 1'b0;
        d4.io_master_bvalid = 1'b1;
        u4.m_bready = 4'b0010;
        #1;
        chk("wb_bvalid", {60'd0, u4.m_bvalid}, 64'b0010);
        chk("wb_bready", {63'd0, d4.io_master_bready}, 64'd1);
        @(negedge clock);
        d4.io_master_bvalid = 1'b0;
        u4.m_bready = '1;
        #1;
        chk("wb_idle_bready", {63'd0, d4.io_master_bready}, 64'd0);
        chk("wb_idle_wready", {60'd0, u4.m_wready}, 64'd0);

        // Two-beat read from m0 with SLVERR on the last beat
        @(negedge clock);
        u4.m_arvalid = 4'b0001;
        @(negedge clock);
        chk("er_arid", {60'd0, d4.io_master_arid}, 64'd0);
        d4.io_master_arready = 1'b1;
        @(negedge clock);
        d4.io_master_arready = 1'b0;
        u4.m_arvalid = '0;
        d4.io_master_rvalid = 1'b1;
        #1;
        chk("er_beat1", {63'd0, err4}, 64'd0);
        @(negedge clock);
        d4.io_master_rresp = 2'b10;
        d4.io_master_rlast = 1'b1;
        #1;
        chk("er_rresp_fwd", {62'd0, u4.m_rresp}, 64'd2);
        @(negedge clock);
        d4.io_master_rvalid = 1'b0;
        d4.io_master_rlast = 1'b0;
        d4.io_master_rresp = 2'b00;
        chk("er_set", {63'd0, err4}, 64'd1);
        run_vec('{4'b0010, 4'b0000, 1'b1, 4'd1});
        chk("er_sticky", {63'd0, err4}, 64'd1);

        // Reset during beat 2 of a 4-beat read from m2 (ptr is 2 here)
        @(negedge clock);
        u4.m_arvalid = 4'b0100;
        @(negedge clock);
        chk("rs_arid", {60'd0, d4.io_master_arid}, 64'd2);
        d4.io_master_arready = 1'b1;
        @(negedge clock);
        d4.io_master_arready = 1'b0;
        u4.m_arvalid = '0;
        d4.io_master_rvalid = 1'b1;
        @(negedge clock);
        #1;
        chk("rs_pre_rvalid", {60'd0, u4.m_rvalid}, 64'b0100);
        reset = 1'b1;
        #1;
        chk("rs_rvalid", {60'd0, u4.m_rvalid}, 64'd0);
        chk("rs_rready", {63'd0, d4.io_master_rready}, 64'd0);
        chk("rs_rdata", {32'd0, u4.m_rdata}, 64'd0);
        chk("rs_arvalid", {63'd0, d4.io_master_arvalid}, 64'd0);
        chk("rs_awvalid", {63'd0, d4.io_master_awvalid}, 64'd0);
        chk("rs_err", {63'd0, err4}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        d4.io_master_rvalid = 1'b0;
        run_vec('{4'b1111, 4'b0000, 1'b1, 4'd0});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
